// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename state (busy bit + ROB tag).
// Optional same-cycle commit-to-read bypass is enabled by defining RF_COMMIT_BYPASS_EN.
module reg_file_rename #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned NREAD = 2,
    localparam int unsigned RID_W = $clog2(NREG)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic [NREAD*RID_W-1:0] rd_id,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_busy,
    output logic [NREAD*TAG_W-1:0] rd_tag,
    input  logic                   iss_valid,
    input  logic [RID_W-1:0]       iss_rd,
    input  logic [TAG_W-1:0]       iss_tag,
    input  logic                   cmt_valid,
    input  logic [RID_W-1:0]       cmt_rd,
    input  logic [TAG_W-1:0]       cmt_tag,
    input  logic [XLEN-1:0]        cmt_data,
    input  logic                   flush_in,
    output logic                   any_busy
);

    logic [XLEN-1:0]  r_val [NREG];
    logic [NREG-1:0]  r_busy;
    logic [TAG_W-1:0] r_tag [NREG];

    logic w_cmt_en;
    logic w_cmt_rel;
    logic w_iss_en;

    assign w_cmt_en  = cmt_valid && (cmt_rd != '0);
    // Only the youngest rename may be released; a stale tag leaves busy/tag alone.
    assign w_cmt_rel = w_cmt_en && r_busy[cmt_rd] && (r_tag[cmt_rd] == cmt_tag);
    assign w_iss_en  = iss_valid && (iss_rd != '0) && !flush_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
            r_busy <= '0;
        end else if (rdy_in) begin
            if (w_cmt_en) begin
                r_val[cmt_rd] <= cmt_data;
            end
            if (flush_in) begin
                r_busy <= '0;
            end else begin
                if (w_cmt_rel) begin
                    r_busy[cmt_rd] <= 1'b0;
                end
                // Placed after the release so a same-register issue wins.
                if (w_iss_en) begin
                    r_busy[iss_rd] <= 1'b1;
                    r_tag[iss_rd]  <= iss_tag;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [RID_W-1:0] w_id;
        logic [XLEN-1:0]  w_data;
        logic             w_busy;
        logic [TAG_W-1:0] w_tag;

        assign w_id = rd_id[gi*RID_W +: RID_W];

        always_comb begin
            w_data = r_val[w_id];
            w_busy = r_busy[w_id];
            w_tag  = r_tag[w_id];
`ifdef RF_COMMIT_BYPASS_EN
            if (rdy_in && w_cmt_en && (w_id == cmt_rd)) begin
                w_data = cmt_data;
                if (w_cmt_rel) begin
                    w_busy = 1'b0;
                end
            end
`endif
            if (w_id == '0) begin
                w_data = '0;
                w_busy = 1'b0;
                w_tag  = '0;
            end
        end

        assign rd_data[gi*XLEN +: XLEN]   = w_data;
        assign rd_busy[gi]                = w_busy;
        assign rd_tag[gi*TAG_W +: TAG_W]  = w_tag;
    end

    assign any_busy = |r_busy;

endmodule

// File: tb/tb_reg_file_rename.sv
// Bench for reg_file_rename: directed vector table, corner sequences, then random traffic
// against an array-based reference model. Honours RF_COMMIT_BYPASS_EN when defined.
module tb_reg_file_rename;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREG  = 32;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned NREAD = 2;
    localparam int unsigned RID_W = 5;

    logic                   clk = 1'b0;
    logic                   rst_in;
    logic                   rdy_in;
    logic [NREAD*RID_W-1:0] rd_id;
    logic [NREAD*XLEN-1:0]  rd_data;
    logic [NREAD-1:0]       rd_busy;
    logic [NREAD*TAG_W-1:0] rd_tag;
    logic                   iss_valid;
    logic [RID_W-1:0]       iss_rd;
    logic [TAG_W-1:0]       iss_tag;
    logic                   cmt_valid;
    logic [RID_W-1:0]       cmt_rd;
    logic [TAG_W-1:0]       cmt_tag;
    logic [XLEN-1:0]        cmt_data;
    logic                   flush_in;
    logic                   any_busy;

    always #5 clk = ~clk;

    reg_file_rename #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .TAG_W (TAG_W),
        .NREAD (NREAD)
    ) u_dut (
        .clk_in    (clk),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .rd_id     (rd_id),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .rd_tag    (rd_tag),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_tag   (iss_tag),
        .cmt_valid (cmt_valid),
        .cmt_rd    (cmt_rd),
        .cmt_tag   (cmt_tag),
        .cmt_data  (cmt_data),
        .flush_in  (flush_in),
        .any_busy  (any_busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // {data, busy, tag} of one read port
    function automatic logic [63:0] port_val(input int p);
        return 64'({rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W]});
    endfunction

    function automatic logic [63:0] pack(input logic [31:0] d, input logic b, input logic [3:0] t);
        return 64'({d, b, t});
    endfunction

    task automatic idle();
        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        iss_valid = 1'b0;
        iss_rd    = '0;
        iss_tag   = '0;
        cmt_valid = 1'b0;
        cmt_rd    = '0;
        cmt_tag   = '0;
        cmt_data  = '0;
        flush_in  = 1'b0;
    endtask

    // Lets the current requests take effect on one edge, then drops them.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic read_check(input string name, input logic [4:0] id, input logic [63:0] exp);
        rd_id = {id, id};
        #1;
        check({name, "_p0"}, port_val(0), exp);
        check({name, "_p1"}, port_val(1), exp);
    endtask

    typedef struct {
        logic        rdy;
        logic        iv;
        logic [4:0]  ird;
        logic [3:0]  itag;
        logic        cv;
        logic [4:0]  crd;
        logic [3:0]  ctag;
        logic [31:0] cdata;
        logic        fl;
        logic [4:0]  rid;
        logic [31:0] edata;
        logic        ebusy;
        logic [3:0]  etag;
        logic        eany;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic iv, input logic [4:0] ird,
                                input logic [3:0] itag, input logic cv, input logic [4:0] crd,
                                input logic [3:0] ctag, input logic [31:0] cdata, input logic fl,
                                input logic [4:0] rid, input logic [31:0] edata,
                                input logic ebusy, input logic [3:0] etag, input logic eany);
        vec_t v;
        v.rdy = rdy; v.iv = iv; v.ird = ird; v.itag = itag;
        v.cv = cv; v.crd = crd; v.ctag = ctag; v.cdata = cdata; v.fl = fl;
        v.rid = rid; v.edata = edata; v.ebusy = ebusy; v.etag = etag; v.eany = eany;
        return v;
    endfunction

    // Reference model state
    logic [31:0] m_val  [NREG];
    logic        m_busy [NREG];
    logic [3:0]  m_tag  [NREG];

    function automatic logic [63:0] model_read(input logic [4:0] id);
        logic [31:0] d;
        logic        b;
        d = m_val[id];
        b = m_busy[id];
`ifdef RF_COMMIT_BYPASS_EN
        if (rdy_in && cmt_valid && cmt_rd != 5'd0 && id == cmt_rd) begin
            d = cmt_data;
            if (m_busy[id] && m_tag[id] == cmt_tag) b = 1'b0;
        end
`endif
        if (id == 5'd0) return 64'd0;
        return pack(d, b, m_tag[id]);
    endfunction

    function automatic logic model_any();
        for (int i = 0; i < NREG; i++) if (m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        logic rel;
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (rdy_in) begin
            rel = cmt_valid && cmt_rd != 5'd0 && m_busy[cmt_rd] && m_tag[cmt_rd] == cmt_tag;
            if (cmt_valid && cmt_rd != 5'd0) m_val[cmt_rd] = cmt_data;
            if (flush_in) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            end else begin
                if (rel) m_busy[cmt_rd] = 1'b0;
                if (iss_valid && iss_rd != 5'd0) begin
                    m_busy[iss_rd] = 1'b1;
                    m_tag[iss_rd]  = iss_tag;
                end
            end
        end
    endtask

    function automatic logic [4:0] rnd_id();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    vec_t vt[17];

    initial begin
        idle();
        rd_id  = '0;
        rst_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b0;
        read_check("rst_x0", 5'd0, 64'd0);
        check("rst_any", 64'(any_busy), 64'd0);

        //            rdy iv ird itag cv crd ctag cdata         fl rid edata         eb et ea
        vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 5, 32'h0,        0, 0, 0);
        vt[1]  = mk(1, 1, 5, 3, 0, 0, 0, 32'h0,        0, 5, 32'h0,        1, 3, 1);
        vt[2]  = mk(1, 0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 5, 32'hDEADBEEF, 0, 3, 0);
        vt[3]  = mk(1, 1, 7, 2, 0, 0, 0, 32'h0,        0, 7, 32'h0,        1, 2, 1);
        vt[4]  = mk(1, 1, 7, 6, 0, 0, 0, 32'h0,        0, 7, 32'h0,        1, 6, 1);
        vt[5]  = mk(1, 0, 0, 0, 1, 7, 2, 32'h11,       0, 7, 32'h11,       1, 6, 1);
        vt[6]  = mk(1, 0, 0, 0, 1, 7, 6, 32'h22,       0, 7, 32'h22,       0, 6, 0);
        vt[7]  = mk(1, 1, 9, 1, 0, 0, 0, 32'h0,        0, 9, 32'h0,        1, 1, 1);
        vt[8]  = mk(1, 1, 9, 4, 1, 9, 1, 32'h55,       0, 9, 32'h55,       1, 4, 1);
        vt[9]  = mk(1, 1, 1, 1, 0, 0, 0, 32'h0,        0, 1, 32'h0,        1, 1, 1);
        vt[10] = mk(1, 1, 2, 2, 0, 0, 0, 32'h0,        0, 2, 32'h0,        1, 2, 1);
        vt[11] = mk(1, 1, 3, 3, 0, 0, 0, 32'h0,        0, 3, 32'h0,        1, 3, 1);
        vt[12] = mk(1, 1, 4, 5, 1, 2, 9, 32'h77,       1, 2, 32'h77,       0, 2, 0);
        vt[13] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 4, 32'h0,        0, 0, 0);
        vt[14] = mk(1, 1, 0, 7, 1, 0, 7, 32'hFFFF,     0, 0, 32'h0,        0, 0, 0);
        vt[15] = mk(0, 1, 6, 5, 0, 0, 0, 32'h0,        0, 6, 32'h0,        0, 0, 0);
        vt[16] = mk(0, 0, 0, 0, 1, 9, 4, 32'h99,       0, 9, 32'h55,       0, 4, 0);

        for (int i = 0; i < 17; i++) begin
            rdy_in    = vt[i].rdy;
            iss_valid = vt[i].iv;
            iss_rd    = vt[i].ird;
            iss_tag   = vt[i].itag;
            cmt_valid = vt[i].cv;
            cmt_rd    = vt[i].crd;
            cmt_tag   = vt[i].ctag;
            cmt_data  = vt[i].cdata;
            flush_in  = vt[i].fl;
            step();
            read_check($sformatf("vec%0d", i), vt[i].rid,
                       pack(vt[i].edata, vt[i].ebusy, vt[i].etag));
            check($sformatf("vec%0d_any", i), 64'(any_busy), 64'(vt[i].eany));
        end
        read_check("flush_x3", 5'd3, pack(32'h0, 1'b0, 4'd3));

        // Same-cycle commit visibility on a busy register
        iss_valid = 1'b1; iss_rd = 5'd5; iss_tag = 4'd3;
        step();
        cmt_valid = 1'b1; cmt_rd = 5'd5; cmt_tag = 4'd3; cmt_data = 32'hAA;
`ifdef RF_COMMIT_BYPASS_EN
        read_check("byp_same", 5'd5, pack(32'hAA, 1'b0, 4'd3));
`else
        read_check("byp_same", 5'd5, pack(32'hDEADBEEF, 1'b1, 4'd3));
`endif
        step();
        read_check("byp_next", 5'd5, pack(32'hAA, 1'b0, 4'd3));

        // Reset mid-operation drops in-flight requests
        iss_valid = 1'b1; iss_rd = 5'd10; iss_tag = 4'd2;
        step();
        iss_valid = 1'b1; iss_rd = 5'd11; iss_tag = 4'd1;
        cmt_valid = 1'b1; cmt_rd = 5'd5; cmt_tag = 4'd0; cmt_data = 32'h1234;
        rst_in = 1'b1;
        step();
        read_check("mrst_x10", 5'd10, 64'd0);
        read_check("mrst_x11", 5'd11, 64'd0);
        read_check("mrst_x5", 5'd5, 64'd0);
        check("mrst_any", 64'(any_busy), 64'd0);

        for (int i = 0; i < NREG; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end

        for (int c = 0; c < 600; c++) begin
            rst_in    = ($urandom_range(0, 99) == 0);
            rdy_in    = ($urandom_range(0, 7) != 0);
            flush_in  = ($urandom_range(0, 15) == 0);
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_rd    = rnd_id();
            iss_tag   = 4'($urandom_range(0, 3));
            cmt_valid = ($urandom_range(0, 1) == 1);
            cmt_rd    = rnd_id();
            cmt_tag   = ($urandom_range(0, 1) == 1) ? m_tag[cmt_rd] : 4'($urandom_range(0, 3));
            cmt_data  = $urandom;
            rd_id[RID_W-1:0]       = ($urandom_range(0, 2) == 0) ? cmt_rd : rnd_id();
            rd_id[2*RID_W-1:RID_W] = ($urandom_range(0, 2) == 0) ? iss_rd : rnd_id();
            #1;
            check($sformatf("rnd%0d_p0", c), port_val(0), model_read(rd_id[RID_W-1:0]));
            check($sformatf("rnd%0d_p1", c), port_val(1), model_read(rd_id[2*RID_W-1:RID_W]));
            check($sformatf("rnd%0d_any", c), 64'(any_busy), 64'(model_any()));
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
